// File: rtl/stim_seq4.sv
// stim_seq4: steps a 4-input netlist through all 16 input vectors.
// Each vector is held HOLD_CYCLES cycles, and 'sample' marks the last cycle.
// The order can be binary, Gray or LFSR.
// Optional macro STIM_CAPTURE_EN adds the resp_in/resp ports. When it is
// defined, the downstream output is captured into a truth table indexed by
// vector value.
module stim_seq4 #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  vec_idx,
  output logic        sample,
  output logic        busy,
  output logic        done
`ifdef STIM_CAPTURE_EN
  ,
  input  logic        resp_in,
  output logic [15:0] resp
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  state_t     state, state_d;
  logic [1:0] mode_q;
  logic [7:0] cnt;
  logic [3:0] idx;
  logic [3:0] lfsr;
  logic [3:0] vec;
  logic       accept;
  logic       last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state. stop overrides everything, including a concurrent start.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = (state == HOLD) && (cnt == HOLD_M1);
    case (state)
      IDLE, DONE: if (start) begin
        state_d = HOLD;
        accept  = 1'b1;
      end
      HOLD: if (last && idx == 4'd15) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  // Hold counter, vector index and LFSR state. The mode is frozen at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      lfsr   <= 4'd1;
      mode_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      idx    <= '0;
      lfsr   <= 4'd1;
      mode_q <= mode;
    end else if (stop) begin
      cnt <= '0;
      idx <= '0;
    end else if (state == HOLD) begin
      if (last) begin
        cnt  <= '0;
        idx  <= idx + 4'd1;
        lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Vector value for the current index.
  // The LFSR never reaches 0000, so index 15 is forced to 0000 to complete
  // the set of 16 values.
  always_comb begin
    case (mode_q)
      2'b01:   vec = idx ^ (idx >> 1);
      2'b10:   vec = (idx == 4'd15) ? 4'd0 : lfsr;
      default: vec = idx;
    endcase
  end

  assign busy         = (state == HOLD);
  assign done         = (state == DONE);
  assign sample       = last;
  assign {a, b, c, d} = busy ? vec : 4'd0;
  assign vec_idx      = busy ? idx : 4'd0;

`ifdef STIM_CAPTURE_EN
  // Truth-table capture, indexed by vector value rather than by vec_idx
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         resp      <= '0;
    else if (accept) resp      <= '0;
    else if (last)   resp[vec] <= resp_in;
  end
`endif

endmodule

// File: tb/tb_stim_seq4.sv
// Directed bench for stim_seq4.
// It covers the three sweep orders, abort and reset, and HOLD_CYCLES=1.
module tb_stim_seq4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop;
  logic [1:0] mode;
  logic       a, b, c, d, sample, busy, done;
  logic [3:0] vec_idx;

  logic       start1, stop1;
  logic [1:0] mode1;
  logic       a1, b1, c1, d1, sample1, busy1, done1;
  logic [3:0] vec_idx1;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef STIM_CAPTURE_EN
  logic        resp_in, resp_in1;
  logic [15:0] resp, resp1;
  assign resp_in  = (~a & c & ~d) | (a & ~c & ~d) | (b & c & ~d);
  assign resp_in1 = 1'b0;
`endif

  stim_seq4 #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .vec_idx(vec_idx),
    .sample(sample), .busy(busy), .done(done)
`ifdef STIM_CAPTURE_EN
    , .resp_in(resp_in), .resp(resp)
`endif
  );

  stim_seq4 #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mode(mode1),
    .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(vec_idx1),
    .sample(sample1), .busy(busy1), .done(done1)
`ifdef STIM_CAPTURE_EN
    , .resp_in(resp_in1), .resp(resp1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [10:0] obs();
    return {vec_idx, a, b, c, d, sample, busy, done};
  endfunction

  // One full sweep from acceptance to done.
  // poke > 0 pulses start and flips mode in that HOLD cycle, and the sweep
  // must not notice either change.
  task automatic sweep(input string nm, input logic [1:0] m,
                       input logic [15:0][3:0] seq, input int poke);
    logic [3:0]  k;
    logic [10:0] e;
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      k = 4'((cyc - 1) / 4);
      e = {k, seq[k], (cyc % 4 == 0), 1'b1, 1'b0};
      chk({nm, "_step"}, 32'(obs()), 32'(e));
`ifdef STIM_CAPTURE_EN
      if (cyc == 1) chk({nm, "_resp_clr"}, 32'(resp), 32'h0);
`endif
      if (cyc == poke) begin start = 1'b1; mode = ~m; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(obs()), 32'h001);
`ifdef STIM_CAPTURE_EN
    chk({nm, "_resp"}, 32'(resp), 32'h5144);
`endif
  endtask

  logic [15:0][3:0] seq_bin, seq_gray, seq_lfsr;
  int ns, nd;

  initial begin
    seq_bin  = 64'hFEDCBA9876543210;
    seq_gray = 64'h89BAEFDC45762310;
    seq_lfsr = 64'h08CEF7B5AD639421;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    start1 = 1'b0; stop1 = 1'b0; mode1 = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(obs()), 32'h0);
`ifdef STIM_CAPTURE_EN
    chk("reset_resp", 32'(resp), 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'(obs()), 32'h0);

    // Binary, then back-to-back Gray from DONE, then LFSR with a mid-sweep poke
    sweep("bin", 2'b00, seq_bin, 0);
    sweep("gray", 2'b01, seq_gray, 0);
    sweep("lfsr", 2'b10, seq_lfsr, 10);
    sweep("mode3", 2'b11, seq_bin, 0);

    // stop when vector 7 is applied
    @(negedge clk); mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (28) @(negedge clk);
    chk("abort_at7", 32'(vec_idx), 32'd7);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("abort_idle", 32'(obs()), 32'h0);
    ns = 0; nd = 0;
    repeat (80) begin
      @(negedge clk);
      ns += int'(sample);
      nd += int'(done);
    end
    chk("abort_nosample", 32'(ns), 32'd0);
    chk("abort_nodone", 32'(nd), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("startstop_idle", 32'(obs()), 32'h0);
    @(negedge clk);
    chk("startstop_idle2", 32'(obs()), 32'h0);

    // async reset mid-HOLD
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'(obs()), 32'h0);
`ifdef STIM_CAPTURE_EN
    chk("rst_resp", 32'(resp), 32'h0);
`endif
    @(negedge clk); rst = 1'b0;
    ns = 0; nd = 0;
    repeat (20) begin
      @(negedge clk);
      ns += int'(sample);
      nd += int'(done | busy);
    end
    chk("rst_quiet_sample", 32'(ns), 32'd0);
    chk("rst_quiet_state", 32'(nd), 32'd0);

    // HOLD_CYCLES=1 gives 16 consecutive sample cycles
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("h1_step", 32'({vec_idx1, a1, b1, c1, d1, sample1, busy1}),
          32'({4'(i), 4'(i), 1'b1, 1'b1}));
      @(negedge clk);
    end
    chk("h1_done", 32'({sample1, busy1, done1}), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
